// File: rtl/burst_main_mem.sv
// Byte-addressed unified main memory with single-word and incrementing burst access.
// Optional sticky out-of-range flag on port addr_err under `define BURST_MAIN_MEM_ADDR_ERR_EN.
module burst_main_mem #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned MEM_BYTES = 1048576,
   parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = ADDR_WIDTH'(32'h8002_0000),
   parameter int unsigned INIT_ZERO = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      wren,
   input  logic [ADDR_WIDTH-1:0]     addr,
   input  logic [1:0]                acc_size,
   input  logic [DATA_WIDTH-1:0]     d_in,
   input  logic [DATA_WIDTH/8-1:0]   be,
   output logic [DATA_WIDTH-1:0]     d_out,
   output logic                      d_valid,
   output logic                      busy
`ifdef BURST_MAIN_MEM_ADDR_ERR_EN
   ,
   output logic                      addr_err
`endif
);

   localparam int unsigned BPW     = DATA_WIDTH / 8;
   localparam int unsigned LOG_BPW = $clog2(BPW);
   localparam int unsigned WORDS   = MEM_BYTES / BPW;
   localparam int unsigned IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int unsigned AXW     = ADDR_WIDTH + 1;

   // Parameter sanity; zero-filling storage at time zero is left to the simulator.
   if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_dw
      $error("burst_main_mem: DATA_WIDTH must be a multiple of 8");
   end
   if (MEM_BYTES == 0 || (MEM_BYTES % BPW) != 0) begin : g_bad_size
      $error("burst_main_mem: MEM_BYTES must be a non-zero multiple of DATA_WIDTH/8");
   end
   if (INIT_ZERO > 1) begin : g_bad_init
      $error("burst_main_mem: INIT_ZERO must be 0 or 1");
   end

   typedef enum logic {IDLE, BURST} state_e;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [3:0]            last_q, last_d;
   logic                  wren_q, wren_d;
   logic [AXW-1:0]        next_q, next_d;
   logic [DATA_WIDTH-1:0] d_out_q, d_out_d;
   logic                  d_valid_q, d_valid_d;
   logic                  busy_q, busy_d;

   logic                  beat_go, beat_wr, in_range;
   logic [AXW-1:0]        beat_addr, beat_off, req_addr;
   logic [IDX_W-1:0]      beat_idx;

   logic [DATA_WIDTH-1:0] mem_q [WORDS];

   localparam logic [AXW-1:0] START_X   = {1'b0, START_ADDRESS};
   localparam logic [AXW-1:0] LAST_OFF  = AXW'(MEM_BYTES - BPW);

   assign req_addr = {1'b0, addr & ~ADDR_WIDTH'(BPW - 1)};

   // Per-beat address decode; arithmetic is one bit wider so low addresses never alias.
   always_comb begin
      beat_off = beat_addr - START_X;
      in_range = (beat_addr >= START_X) && (beat_off <= LAST_OFF);
      beat_idx = IDX_W'(beat_off >> LOG_BPW);
   end

   // Next-state, beat sequencing and output data.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      wren_d    = wren_q;
      next_d    = next_q;
      beat_go   = 1'b0;
      beat_wr   = 1'b0;
      beat_addr = req_addr;
      case (state_q)
         IDLE: begin
            if (enable) begin
               beat_go   = 1'b1;
               beat_wr   = wren;
               beat_addr = req_addr;
               wren_d    = wren;
               next_d    = req_addr + AXW'(BPW);
               case (acc_size)
                  2'b00:   last_d = 4'd0;
                  2'b01:   last_d = 4'd3;
                  2'b10:   last_d = 4'd7;
                  default: last_d = 4'd15;
               endcase
               if (acc_size != 2'b00) begin
                  state_d = BURST;
                  cnt_d   = 4'd1;
               end
            end
         end
         default: begin
            beat_go   = 1'b1;
            beat_wr   = wren_q;
            beat_addr = next_q;
            next_d    = next_q + AXW'(BPW);
            if (cnt_q == last_q) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
      endcase
      busy_d    = (state_d == BURST);
      d_valid_d = beat_go && !beat_wr;
      d_out_d   = d_out_q;
      if (d_valid_d) begin
         d_out_d = in_range ? mem_q[beat_idx] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         last_q    <= 4'd0;
         wren_q    <= 1'b0;
         next_q    <= '0;
         d_out_q   <= '0;
         d_valid_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         wren_q    <= wren_d;
         next_q    <= next_d;
         d_out_q   <= d_out_d;
         d_valid_q <= d_valid_d;
         busy_q    <= busy_d;
      end
   end

   // Byte-lane writes; lane 0 (be MSB) is the lowest address, big-endian.
   always_ff @(posedge clk) begin
      if (!reset && beat_go && beat_wr && in_range) begin
         for (int j = 0; j < int'(BPW); j++) begin
            if (be[BPW-1-j]) begin
               mem_q[beat_idx][DATA_WIDTH-1-8*j -: 8] <= d_in[DATA_WIDTH-1-8*j -: 8];
            end
         end
      end
   end

   assign d_out   = d_out_q;
   assign d_valid = d_valid_q;
   assign busy    = busy_q;

`ifdef BURST_MAIN_MEM_ADDR_ERR_EN
   logic addr_err_q, addr_err_d;

   // Cleared by acceptance, then set by any out-of-range beat including beat 0.
   always_comb begin
      addr_err_d = addr_err_q;
      if (state_q == IDLE && enable) begin
         addr_err_d = 1'b0;
      end
      if (beat_go && !in_range) begin
         addr_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_err_q <= 1'b0;
      end else begin
         addr_err_q <= addr_err_d;
      end
   end

   assign addr_err = addr_err_q;
`endif

endmodule
